// File: rtl/div_iterative_param_if.sv
// Issue/result bus of the iterative divider: op request in, tagged result out,
// plus the pipeline kill.
interface div_iterative_param_if #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 12
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_op;
  logic [WIDTH-1:0]     in_A;
  logic [WIDTH-1:0]     in_B;
  logic [TAG_WIDTH-1:0] in_tag;
  logic                 flush;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     out_data;
  logic [TAG_WIDTH-1:0] out_tag;
  logic                 out_cache_hit;

  modport master (
    output in_valid, in_op, in_A, in_B, in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag, out_cache_hit
  );

  modport slave (
    input  in_valid, in_op, in_A, in_B, in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag, out_cache_hit
  );
endinterface

// File: rtl/div_iterative_param.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle,
// with fast paths for divide-by-zero, signed overflow and a one-entry result cache.
module div_iterative_param #(
  parameter int WIDTH     = 32,
  parameter int TAG_WIDTH = 12
) (
  input  logic CLK,
  input  logic nRST,
  div_iterative_param_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} state_t;
  state_t st, st_n;

  logic [WIDTH-1:0]     q, r, bm, res;
  logic [CW-1:0]        cnt;
  logic                 neg_q, neg_r, is_rem, hit_r;
  logic [TAG_WIDTH-1:0] tag;
  // operands of the in-flight divide, written into the cache on completion
  logic [WIDTH-1:0]     pa, pb;
  logic                 pu;
  logic                 c_vld, c_uns;
  logic [WIDTH-1:0]     c_a, c_b, c_q, c_r;

  logic             acc, uns, sa, sb, hit, dz, ovf, fast, ge, last;
  logic [WIDTH-1:0] a_mag, b_mag, sq, sr, r_nx, q_nx, qf, rf;
  logic [WIDTH:0]   r_sh;

  always_comb begin
    bus.in_ready = ~bus.flush & ((st == IDLE) | ((st == DONE) & bus.out_ready));
    acc   = bus.in_valid & bus.in_ready;
    uns   = bus.in_op[0];
    sa    = ~uns & bus.in_A[WIDTH-1];
    sb    = ~uns & bus.in_B[WIDTH-1];
    a_mag = sa ? -bus.in_A : bus.in_A;
    b_mag = sb ? -bus.in_B : bus.in_B;
    hit   = c_vld & (bus.in_A == c_a) & (bus.in_B == c_b) & (uns == c_uns);
    dz    = (bus.in_B == '0);
    ovf   = ~uns & (bus.in_A == MINV) & (bus.in_B == '1);
    fast  = hit | dz | ovf;
    sq    = dz ? '1 : bus.in_A;
    sr    = dz ? bus.in_A : '0;
    // restoring step; the shifted remainder needs one extra bit
    r_sh  = {r, q[WIDTH-1]};
    ge    = (r_sh >= {1'b0, bm});
    r_nx  = ge ? WIDTH'(r_sh - {1'b0, bm}) : r_sh[WIDTH-1:0];
    q_nx  = {q[WIDTH-2:0], ge};
    qf    = neg_q ? -q_nx : q_nx;
    rf    = neg_r ? -r_nx : r_nx;
    last  = (st == DIVIDE) & (cnt == '0);
  end

  always_comb begin
    st_n = st;
    if (bus.flush)  st_n = IDLE;
    else if (acc)   st_n = fast ? DONE : DIVIDE;
    else begin
      case (st)
        DIVIDE:  if (cnt == '0) st_n = DONE;
        DONE:    if (bus.out_ready) st_n = IDLE;
        default: st_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) st <= IDLE;
    else       st <= st_n;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      q <= '0; r <= '0; bm <= '0; res <= '0; cnt <= '0;
      neg_q <= 1'b0; neg_r <= 1'b0; is_rem <= 1'b0; hit_r <= 1'b0; tag <= '0;
      pa <= '0; pb <= '0; pu <= 1'b0;
      c_vld <= 1'b0; c_uns <= 1'b0; c_a <= '0; c_b <= '0; c_q <= '0; c_r <= '0;
    end else if (!bus.flush) begin
      if (acc) begin
        tag    <= bus.in_tag;
        is_rem <= bus.in_op[1];
        hit_r  <= hit;
        if (hit) begin
          res <= bus.in_op[1] ? c_r : c_q;
        end else if (dz | ovf) begin
          res   <= bus.in_op[1] ? sr : sq;
          c_vld <= 1'b1; c_uns <= uns; c_a <= bus.in_A; c_b <= bus.in_B;
          c_q   <= sq;   c_r   <= sr;
        end else begin
          q     <= a_mag;
          r     <= '0;
          bm    <= b_mag;
          cnt   <= CW'(WIDTH-1);
          neg_q <= sa ^ sb;
          neg_r <= sa;
          pa <= bus.in_A; pb <= bus.in_B; pu <= uns;
        end
      end else if (st == DIVIDE) begin
        q   <= q_nx;
        r   <= r_nx;
        cnt <= cnt - CW'(1);
        if (last) begin
          res   <= is_rem ? rf : qf;
          c_vld <= 1'b1; c_uns <= pu; c_a <= pa; c_b <= pb;
          c_q   <= qf;   c_r   <= rf;
        end
      end
    end
  end

  always_comb begin
    bus.out_valid     = (st == DONE);
    bus.out_data      = res;
    bus.out_tag       = tag;
    bus.out_cache_hit = hit_r;
  end
endmodule
